lfsr_stream: RTL and testbench



---
 rtl/lfsr_pkg.sv | 41 ++++
 rtl/lfsr_step.sv | 27 ++
 rtl/lfsr_stream.sv | 97 +++++++++
 tb/tb_lfsr_stream.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lfsr_pkg: mode encodings, default masks and next-state functions. Rev 1.0
// ----------------------------------------------------------------------------
package lfsr_pkg;

  typedef enum logic {
    MODE_FIB = 1'b0,
    MODE_GAL = 1'b1
  } mode_e;

  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [7:0]  POLY_W8  = 8'h1D;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [15:0] POLY_W16 = 16'h100B;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;
  localparam logic [31:0] POLY_W32 = 32'h0000_00C5;

  function automatic logic [31:0] width_mask(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Shift toward the MSB; the parity of the tapped bits enters at bit 0.
  function automatic logic [31:0] fib_next(input logic [31:0] s,
                                           input logic [31:0] taps,
                                           input int unsigned w);
    logic fb;
    fb = ^(s & taps);
    return ((s << 1) | {31'd0, fb}) & width_mask(w);
  endfunction

  function automatic logic [31:0] gal_next(input logic [31:0] s,
                                           input logic [31:0] poly,
                                           input int unsigned w);
    logic msb;
    msb = |(s & (32'd1 << (w - 1)));
    return ((s << 1) & width_mask(w)) ^ (msb ? poly : 32'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lfsr_step: combinational one-step LFSR successor for either form. Rev 1.0
// ----------------------------------------------------------------------------
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] s_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] taps_i,
  input  logic [WIDTH-1:0] poly_i,
  output logic [WIDTH-1:0] next_o
);

  always_comb begin
    next_o = s_i;
    case (mode_e'(mode_i))
      MODE_FIB: next_o = WIDTH'(fib_next(32'(s_i), 32'(taps_i), WIDTH));
      MODE_GAL: next_o = WIDTH'(gal_next(32'(s_i), 32'(poly_i), WIDTH));
      default:  next_o = s_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lfsr_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lfsr_stream: valid/ready pseudo-random word source with load and period flag.
// Rev 1.0
// ----------------------------------------------------------------------------
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W8),
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(POLY_W8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h01),
  parameter int unsigned      CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             MODE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_DATA,
  output logic [WIDTH-1:0] O,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [CNT_W-1:0] COUNT,
  output logic             PERIOD,
  output logic             ZERO_FIX
);

  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             per_q, per_d;
  logic             zf_q, zf_d;
  logic [WIDTH-1:0] next_w;
  logic [WIDTH-1:0] load_val_w;
  logic             adv_w;

  lfsr_step #(.WIDTH(WIDTH)) u_step (
    .s_i    (s_q),
    .mode_i (MODE),
    .taps_i (TAPS),
    .poly_i (POLY),
    .next_o (next_w)
  );

  assign adv_w      = valid_q & O_READY & ~LOAD;
  assign load_val_w = (LOAD_DATA == '0) ? SEED : LOAD_DATA;

  // Load beats the lock-up guard, which beats a normal advance.
  always_comb begin
    s_d     = s_q;
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    valid_d = 1'b1;
    per_d   = 1'b0;
    zf_d    = zf_q;
    if (LOAD) begin
      s_d   = load_val_w;
      ref_d = load_val_w;
      cnt_d = '0;
      if (LOAD_DATA == '0) zf_d = 1'b1;
    end else if (s_q == '0) begin
      s_d  = SEED;
      zf_d = 1'b1;
    end else if (adv_w) begin
      s_d   = next_w;
      cnt_d = cnt_q + CNT_W'(1);
      per_d = (next_w == ref_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      s_q     <= SEED;
      ref_q   <= SEED;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      per_q   <= 1'b0;
      zf_q    <= 1'b0;
    end else begin
      s_q     <= s_d;
      ref_q   <= ref_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      per_q   <= per_d;
      zf_q    <= zf_d;
    end
  end

  assign O        = s_q;
  assign O_VALID  = valid_q;
  assign COUNT    = cnt_q;
  assign PERIOD   = per_q;
  assign ZERO_FIX = zf_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lfsr_stream: directed and random stimulus against an arithmetic model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_lfsr_stream;

  localparam int TAPS = 'hB8;
  localparam int POLY = 'h1D;
  localparam int SEED = 'h01;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       MODE = 1'b0;
  logic       LOAD = 1'b0;
  logic [7:0] LOAD_DATA = 8'h00;
  logic [7:0] O;
  logic       O_VALID;
  logic       O_READY = 1'b0;
  logic [15:0] COUNT;
  logic       PERIOD;
  logic       ZERO_FIX;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_s, m_ref, m_cnt;
  bit m_v, m_per, m_zf;

  lfsr_stream #(
    .WIDTH(8), .TAPS(8'hB8), .POLY(8'h1D), .SEED(8'h01), .CNT_W(16)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .MODE(MODE), .LOAD(LOAD), .LOAD_DATA(LOAD_DATA),
    .O(O), .O_VALID(O_VALID), .O_READY(O_READY), .COUNT(COUNT),
    .PERIOD(PERIOD), .ZERO_FIX(ZERO_FIX)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int ref_next(input int s, input bit md);
    if (!md) return ((s * 2) % 256) + ($countones(s & TAPS) % 2);
    return ((s * 2) % 256) ^ ((s >= 128) ? POLY : 0);
  endfunction

  task automatic model_edge(input bit rstn, input bit ld, input bit rdy,
                            input bit md, input int d);
    bit accept;
    int nx;
    if (!rstn) begin
      m_s = SEED; m_ref = SEED; m_cnt = 0; m_v = 0; m_per = 0; m_zf = 0;
      return;
    end
    accept = m_v && rdy && !ld;
    m_v    = 1;
    m_per  = 0;
    if (ld) begin
      m_s = (d == 0) ? SEED : d;
      m_ref = m_s;
      m_cnt = 0;
      if (d == 0) m_zf = 1;
    end else if (m_s == 0) begin
      m_s = SEED; m_zf = 1;
    end else if (accept) begin
      nx = ref_next(m_s, md);
      m_s = nx;
      m_cnt = (m_cnt + 1) % 65536;
      m_per = (nx == m_ref);
    end
  endtask

  task automatic cycle(input bit rstn, input bit ld, input bit rdy,
                       input bit md, input logic [7:0] d);
    RESETN = rstn; LOAD = ld; O_READY = rdy; MODE = md; LOAD_DATA = d;
    @(posedge CLK);
    model_edge(rstn, ld, rdy, md, int'(d));
    #1;
    check("O", 32'(O), 32'(m_s));
    check("O_VALID", 32'(O_VALID), 32'(m_v));
    check("COUNT", 32'(COUNT), 32'(m_cnt));
    check("PERIOD", 32'(PERIOD), 32'(m_per));
    check("ZERO_FIX", 32'(ZERO_FIX), 32'(m_zf));
  endtask

  logic [7:0] fib_head [4];
  int pulses, first_pulse_cnt;

  initial begin
    fib_head[0] = 8'h02; fib_head[1] = 8'h04; fib_head[2] = 8'h08; fib_head[3] = 8'h11;

    // reset state
    cycle(0, 0, 1, 0, 8'h00);
    cycle(0, 0, 1, 0, 8'h00);
    check("rst_O", 32'(O), 32'h01);
    check("rst_valid", 32'(O_VALID), 32'h0);

    // Fibonacci free run, period pulses
    cycle(1, 0, 1, 0, 8'h00);
    check("valid_rise", 32'(O_VALID), 32'h1);
    check("first_O", 32'(O), 32'h01);
    pulses = 0; first_pulse_cnt = -1;
    for (int i = 0; i < 600; i++) begin
      cycle(1, 0, 1, 0, 8'h00);
      if (i < 4) check("fib_head", 32'(O), 32'(fib_head[i]));
      if (PERIOD) begin
        if (pulses == 0) first_pulse_cnt = int'(COUNT);
        pulses++;
      end
    end
    check("period_pulses", 32'(pulses), 32'd2);
    check("period_first_cnt", 32'(first_pulse_cnt), 32'd255);

    // Galois from 0x80
    cycle(1, 1, 1, 1, 8'h80);
    cycle(1, 0, 1, 1, 8'h00);
    check("gal_first", 32'(O), 32'h1D);
    check("gal_cnt1", 32'(COUNT), 32'd1);
    for (int i = 0; i < 254; i++) cycle(1, 0, 1, 1, 8'h00);
    check("gal_period", 32'(PERIOD), 32'h1);
    check("gal_back", 32'(O), 32'h80);

    // stalls
    cycle(0, 0, 0, 0, 8'h00);
    cycle(1, 0, 0, 0, 8'h00);
    cycle(1, 0, 1, 0, 8'h00);
    cycle(1, 0, 0, 0, 8'h00);
    cycle(1, 0, 0, 0, 8'h00);
    check("stall_hold", 32'(O), 32'h02);
    cycle(1, 0, 1, 0, 8'h00);
    check("stall_next", 32'(O), 32'h04);
    check("stall_cnt", 32'(COUNT), 32'd2);

    // zero load and sticky flag
    cycle(1, 1, 0, 0, 8'h00);
    check("zload_O", 32'(O), 32'h01);
    check("zload_fix", 32'(ZERO_FIX), 32'h1);
    cycle(1, 1, 1, 0, 8'h5A);
    check("load_pri_O", 32'(O), 32'h5A);
    check("load_pri_cnt", 32'(COUNT), 32'd0);
    check("zfix_sticky", 32'(ZERO_FIX), 32'h1);
    cycle(0, 1, 1, 0, 8'h77);
    check("rst_wins_O", 32'(O), 32'h01);
    check("rst_wins_valid", 32'(O_VALID), 32'h0);
    check("rst_clr_fix", 32'(ZERO_FIX), 32'h0);
    cycle(1, 1, 0, 0, 8'hC3);
    check("load_novalid", 32'(O), 32'hC3);

    // mid-run reset at COUNT=37
    for (int i = 0; i < 37; i++) cycle(1, 0, 1, 0, 8'h00);
    check("cnt37", 32'(COUNT), 32'd37);
    cycle(0, 0, 1, 0, 8'h00);
    check("mid_rst_cnt", 32'(COUNT), 32'd0);
    check("mid_rst_valid", 32'(O_VALID), 32'h0);
    cycle(1, 0, 1, 0, 8'h00);
    check("mid_rel_valid", 32'(O_VALID), 32'h1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, l, rd, md;
      logic [7:0] d;
      r  = ($urandom_range(499) != 0);
      l  = ($urandom_range(19) == 0);
      rd = ($urandom_range(3) != 0);
      md = ($urandom_range(63) == 0) ? ~MODE : MODE;
      d  = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
      cycle(r, l, rd, md, d);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
